cordic_8b_rr_seq: RTL and testbench
===================================

Name: cordic_8b_rr_seq

Overview:
- Iterative, time-multiplexed implementation of the 8-bit CORDIC datapath. One shared iteration stage is reused over ITERS clock cycles instead of being unrolled.
- Two requesters share the engine through a round-robin arbiter using valid/ready handshakes.
- Results leave on a single valid/ready output channel, tagged with the requester ID.
- Sits between the angle-generation clients and downstream consumers. It replaces the unrolled combinational CORDIC where area matters more than throughput.

Parameters:
- ITERS, 8, number of CORDIC iterations performed per job (legal 1..8). Iteration i uses shift i and angle 128>>i.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s0_valid  input  1  requester 0 job valid
- s0_ready  output  1  requester 0 job accepted this cycle
- s0_x, s0_y, s0_z  input  8 each  requester 0 operands
- s1_valid  input  1  requester 1 job valid
- s1_ready  output  1  requester 1 job accepted this cycle
- s1_x, s1_y, s1_z  input  8 each  requester 1 operands
- m_valid  output  1  result valid
- m_ready  input  1  downstream accepts result
- m_x, m_y, m_z  output  8 each  result
- m_id  output  1  requester that issued the result
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; iter=0; last_grant=1, so requester 0 wins the first tie.
  - m_valid=0; m_x=m_y=m_z=0; m_id=0; busy=0.
  - Reset mid-job discards the job silently. No output is produced for it.
- States IDLE, RUN, DONE:
  - IDLE: grant0 = s0_valid & (~s1_valid | last_grant==1); grant1 = s1_valid & ~grant0. s0_ready=grant0, s1_ready=grant1; these are combinational from valid and only asserted in IDLE.
  - Acceptance edge in IDLE: load x/y/z from the winner, record m_id, set last_grant=winner, iter=0, go to RUN.
  - RUN: each clock applies iteration iter, then increments iter. When iter==ITERS-1 is applied, go to DONE.
  - DONE: m_valid=1 and registers hold. On m_valid & m_ready go to IDLE; no new job is accepted in that same cycle.
- Iteration i, unsigned 8-bit modulo-256 arithmetic with logical shifts:
  - d = z[7].
  - d=1: x' = x + (y>>i); y' = y - (x>>i); z' = z + (128>>i).
  - d=0: x' = x - (y>>i); y' = y + (x>>i); z' = z - (128>>i).
  - x' and y' use the pre-update x and y.
  - With ITERS=8, results are bit-exact to the unrolled 8-stage CORDIC. The bench uses that model as golden.
- Latency: the acceptance edge is E0. Iterations apply at edges E1..E_ITERS. m_valid goes high after E_ITERS.
- Minimum job period is ITERS+2 cycles (accept, ITERS run cycles, one DONE cycle with m_ready=1).
- Backpressure: m_ready=0 holds DONE indefinitely with m_* stable; s*_ready stays 0 throughout.
- Requesters may drop or change s*_valid while not granted; no state changes.
- busy = (state != IDLE).

Test Plan:
- Reset, then s0 with x=0,y=0,z=0 and m_ready=1 -> s0_ready=1 in one cycle; m_valid rises 8 cycles later with m_x=0x00, m_y=0x00, m_z=0xFF, m_id=0.
- s1 with x=16,y=0,z=0 -> m_x=52 (0x34), m_y=253 (0xFD), m_z=255 (0xFF), m_id=1, latency 8.
- s0 and s1 both valid continuously for 4 jobs -> grant order 0,1,0,1 and m_id sequence matches; each job's result is golden-exact.
- m_ready held 0 for 20 cycles after m_valid -> m_* stable, busy=1, s0_ready=s1_ready=0. Raising m_ready completes the handshake, and the next job is accepted on the following cycle.
- Assert rst_n=0 at iteration 4 of a job -> all outputs 0 immediately. After release, no stale m_valid; a new job computes correctly.
- 1000 random jobs on random valid/m_ready patterns -> every result matches the unrolled model; no job lost or duplicated; per-requester order preserved.

Source files
------------

// File: rtl/cordic_8b_rr_seq.sv
// ---------------------------------------------------------------------------
// cordic_8b_rr_seq
//
// Iterative 8-bit CORDIC engine. One add/sub/shift stage is reused over ITERS
// clock cycles. Two requesters share it through a round-robin arbiter, and
// each result goes out on one valid/ready channel tagged with the ID of the
// requester that issued it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s0_valid / s0_ready   requester 0 job handshake; operands s0_x/s0_y/s0_z
//   s1_valid / s1_ready   requester 1 job handshake; operands s1_x/s1_y/s1_z
//   m_valid / m_ready     result handshake; result m_x/m_y/m_z, tag m_id
//   busy                  engine is running a job or holding a result
//
// Parameter:
//   ITERS                 iterations per job (1..8); iteration i uses
//                         shift i and angle 128>>i
// ---------------------------------------------------------------------------
module cordic_8b_rr_seq #(
    parameter int ITERS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s0_x,
    input  logic [7:0] s0_y,
    input  logic [7:0] s0_z,
    input  logic       s1_valid,
    output logic       s1_ready,
    input  logic [7:0] s1_x,
    input  logic [7:0] s1_y,
    input  logic [7:0] s1_z,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_x,
    output logic [7:0] m_y,
    output logic [7:0] m_z,
    output logic       m_id,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    logic [1:0] state_reg, state_next;
    logic [2:0] iter_reg, iter_next;
    logic       last_grant_reg, last_grant_next;
    logic [7:0] x_reg, x_next;
    logic [7:0] y_reg, y_next;
    logic [7:0] z_reg, z_next;
    logic       id_reg, id_next;

    logic       grant0;
    logic       grant1;
    logic [7:0] x_sh;
    logic [7:0] y_sh;
    logic [7:0] angle;

    // Elementary rotation angles: entry i is 128>>i.
    logic [7:0] angle_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_angle
            assign angle_tab[gi] = 8'h80 >> gi;
        end
    endgenerate

    // Arbitration is only meaningful in IDLE. last_grant_reg==1 means
    // requester 1 won most recently, so requester 0 takes the next tie.
    assign grant0 = (state_reg == ST_IDLE) && s0_valid &&
                    (!s1_valid || last_grant_reg);
    assign grant1 = (state_reg == ST_IDLE) && s1_valid && !grant0;

    assign s0_ready = grant0;
    assign s1_ready = grant1;

    // Both shifts read the pre-update x and y.
    assign x_sh  = x_reg >> iter_reg;
    assign y_sh  = y_reg >> iter_reg;
    assign angle = angle_tab[iter_reg];

    always_comb begin
        state_next      = state_reg;
        iter_next       = iter_reg;
        last_grant_next = last_grant_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        z_next          = z_reg;
        id_next         = id_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant0) begin
                    x_next          = s0_x;
                    y_next          = s0_y;
                    z_next          = s0_z;
                    id_next         = 1'b0;
                    last_grant_next = 1'b0;
                    iter_next       = 3'd0;
                    state_next      = ST_RUN;
                end else if (grant1) begin
                    x_next          = s1_x;
                    y_next          = s1_y;
                    z_next          = s1_z;
                    id_next         = 1'b1;
                    last_grant_next = 1'b1;
                    iter_next       = 3'd0;
                    state_next      = ST_RUN;
                end
            end

            ST_RUN: begin
                // The sign bit of z picks the rotation direction.
                if (z_reg[7]) begin
                    x_next = x_reg + y_sh;
                    y_next = y_reg - x_sh;
                    z_next = z_reg + angle;
                end else begin
                    x_next = x_reg - y_sh;
                    y_next = y_reg + x_sh;
                    z_next = z_reg - angle;
                end
                iter_next = iter_reg + 3'd1;
                if (iter_reg == LAST_ITER) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // Going back to IDLE takes one cycle, so a new job cannot be
                // accepted in the same cycle the result is taken.
                if (m_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            iter_reg       <= 3'd0;
            last_grant_reg <= 1'b1;
            x_reg          <= 8'd0;
            y_reg          <= 8'd0;
            z_reg          <= 8'd0;
            id_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            iter_reg       <= iter_next;
            last_grant_reg <= last_grant_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            z_reg          <= z_next;
            id_reg         <= id_next;
        end
    end

    assign m_valid = (state_reg == ST_DONE);
    assign m_x     = x_reg;
    assign m_y     = y_reg;
    assign m_z     = z_reg;
    assign m_id    = id_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cordic_8b_rr_seq.sv
// ---------------------------------------------------------------------------
// tb_cordic_8b_rr_seq
//
// Scoreboard bench for cordic_8b_rr_seq. When a job is accepted, its expected
// result (from an unrolled CORDIC model) is pushed into a queue. A monitor
// process, which runs on the falling edge, pops the queue on every result
// handshake and compares. A small reference FSM in the monitor also predicts
// ready, m_valid and busy on every cycle. Directed phases check the
// hand-computed vectors, the arbitration order, backpressure and reset in the
// middle of a job. A random phase then runs about 1000 jobs.
// ---------------------------------------------------------------------------
module tb_cordic_8b_rr_seq;

    localparam int ITERS = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s1_valid;
    logic       s0_ready, s1_ready;
    logic [7:0] s0_x, s0_y, s0_z;
    logic [7:0] s1_x, s1_y, s1_z;
    logic       m_valid, m_ready;
    logic [7:0] m_x, m_y, m_z;
    logic       m_id;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic       id;
    } job_t;

    job_t exp_q[$];

    always #5 clk = ~clk;

    cordic_8b_rr_seq #(.ITERS(ITERS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_x     (s0_x),
        .s0_y     (s0_y),
        .s0_z     (s0_z),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_x     (s1_x),
        .s1_y     (s1_y),
        .s1_z     (s1_z),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_x      (m_x),
        .m_y      (m_y),
        .m_z      (m_z),
        .m_id     (m_id),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Unrolled reference CORDIC.
    function automatic job_t golden(input logic [7:0] x0, input logic [7:0] y0,
                                    input logic [7:0] z0, input logic id);
        logic [7:0] x, y, z, nx;
        job_t r;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < ITERS; i++) begin
            if (z[7]) begin
                nx = x + (y >> i);
                y  = y - (x >> i);
                z  = z + (8'h80 >> i);
            end else begin
                nx = x - (y >> i);
                y  = y + (x >> i);
                z  = z - (8'h80 >> i);
            end
            x = nx;
        end
        r.x = x; r.y = y; r.z = z; r.id = id;
        return r;
    endfunction

    // Monitor, scoreboard and reference FSM (0 idle, 1 run, 2 done).
    initial begin
        int   st;
        int   cnt;
        logic last;
        logic e0, e1;
        job_t e;
        st = 0; cnt = 0; last = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                // Any job in flight is discarded silently.
                if (st != 0 && exp_q.size() > 0) void'(exp_q.pop_back());
                st = 0; cnt = 0; last = 1'b1;
            end else begin
                e0 = (st == 0) && s0_valid && (!s1_valid || last);
                e1 = (st == 0) && s1_valid && !e0;
                chk("s0_ready", s0_ready, e0);
                chk("s1_ready", s1_ready, e1);
                chk("m_valid", m_valid, st == 2);
                chk("busy", busy, st != 0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_x", m_x, e.x);
                        chk("res_y", m_y, e.y);
                        chk("res_z", m_z, e.z);
                        chk("res_id", m_id, e.id);
                    end
                end
                case (st)
                    0: begin
                        if (e0) begin
                            exp_q.push_back(golden(s0_x, s0_y, s0_z, 1'b0));
                            last = 1'b0; st = 1; cnt = 0;
                        end else if (e1) begin
                            exp_q.push_back(golden(s1_x, s1_y, s1_z, 1'b1));
                            last = 1'b1; st = 1; cnt = 0;
                        end
                    end
                    1: begin
                        cnt++;
                        if (cnt == ITERS) st = 2;
                    end
                    default: begin
                        if (m_ready) st = 0;
                    end
                endcase
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Returns at the falling edge where either requester is granted.
    task automatic wait_grant(output logic winner);
        int n;
        n = 0;
        winner = 1'b0;
        while (!(s0_ready || s1_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(s0_ready || s1_ready)) chk("grant_timeout", 0, 1);
        winner = s1_ready;
    endtask

    // Call just after the acceptance edge. Counts edges until m_valid is seen.
    task automatic wait_mvalid(output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (m_valid || cycles > 100) break;
            @(posedge clk);
            cycles++;
        end
        if (!m_valid) chk("mvalid_timeout", 0, 1);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 500);
        if (busy || exp_q.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_result(input string tag, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] z, input logic id);
        chk({tag, "_x"}, m_x, x);
        chk({tag, "_y"}, m_y, y);
        chk({tag, "_z"}, m_z, z);
        chk({tag, "_id"}, m_id, id);
    endtask

    initial begin
        logic w;
        int   lat;
        int   issued;
        int   guard;
        logic acc0, acc1;
        logic exp_order [4];

        rst_n = 1'b0; m_ready = 1'b1;
        s0_valid = 0; s0_x = 0; s0_y = 0; s0_z = 0;
        s1_valid = 0; s1_x = 0; s1_y = 0; s1_z = 0;
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_x", m_x, 0);
        chk("rst_m_y", m_y, 0);
        chk("rst_m_z", m_z, 0);
        chk("rst_m_id", m_id, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Job 1: s0 (0,0,0) gives (0x00, 0x00, 0xFF).
        s0_x = 8'd0; s0_y = 8'd0; s0_z = 8'd0; s0_valid = 1;
        wait_grant(w);
        chk("job1_winner", w, 0);
        step();
        s0_valid = 0;
        wait_mvalid(lat);
        chk("job1_latency", lat, ITERS);
        chk_result("job1", 8'h00, 8'h00, 8'hFF, 1'b0);
        wait_idle();

        // Job 2: s1 (16,0,0) gives (52, 253, 255).
        step();
        s1_x = 8'd16; s1_y = 8'd0; s1_z = 8'd0; s1_valid = 1;
        wait_grant(w);
        chk("job2_winner", w, 1);
        step();
        s1_valid = 0;
        wait_mvalid(lat);
        chk("job2_latency", lat, ITERS);
        chk_result("job2", 8'd52, 8'd253, 8'd255, 1'b1);
        wait_idle();

        // Both requesters valid all the time: grants alternate 0,1,0,1.
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        step();
        s0_x = 8'd100; s0_y = 8'd20; s0_z = 8'd40;  s0_valid = 1;
        s1_x = 8'd7;   s1_y = 8'd90; s1_z = 8'd200; s1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(w);
            chk("grant_order", w, exp_order[k]);
            step();
            if (w) begin
                s1_x = s1_x + 8'd33; s1_y = s1_y ^ 8'h5A; s1_z = s1_z + 8'd77;
            end else begin
                s0_x = s0_x + 8'd61; s0_y = s0_y + 8'd13; s0_z = s0_z ^ 8'hC3;
            end
        end
        s0_valid = 0; s1_valid = 0;
        wait_idle();

        // Backpressure: the result is held for 20 cycles while s0 keeps asking.
        step();
        m_ready = 0;
        s1_x = 8'd16; s1_y = 8'd0; s1_z = 8'd0; s1_valid = 1;
        wait_grant(w);
        step();
        s1_valid = 0;
        s0_x = 8'd0; s0_y = 8'd0; s0_z = 8'd0; s0_valid = 1;
        wait_mvalid(lat);
        for (int k = 0; k < 20; k++) begin
            chk_result("hold", 8'd52, 8'd253, 8'd255, 1'b1);
            chk("hold_s0_ready", s0_ready, 0);
            @(negedge clk);
        end
        step();
        m_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hold_accept", s0_ready, 1);
        step();
        s0_valid = 0;
        wait_idle();

        // Reset in the middle of a job.
        step();
        s1_x = 8'h55; s1_y = 8'h33; s1_z = 8'h10; s1_valid = 1;
        wait_grant(w);
        step();
        s1_valid = 0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_m_x", m_x, 0);
        chk("midrst_m_y", m_y, 0);
        chk("midrst_m_z", m_z, 0);
        chk("midrst_m_id", m_id, 0);
        chk("midrst_s0_ready", s0_ready, 0);
        chk("midrst_s1_ready", s1_ready, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (12) step();
        s0_x = 8'd16; s0_y = 8'd0; s0_z = 8'd0; s0_valid = 1;
        wait_grant(w);
        chk("postrst_winner", w, 0);
        step();
        s0_valid = 0;
        wait_mvalid(lat);
        chk("postrst_latency", lat, ITERS);
        chk_result("postrst", 8'd52, 8'd253, 8'd255, 1'b0);
        wait_idle();

        // Random traffic: valids, operands and m_ready all random.
        issued = 0; guard = 0;
        step();
        while (issued < 1000 && guard < 60000) begin
            @(negedge clk);
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            issued += int'(acc0) + int'(acc1);
            guard++;
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 3) != 0);
            if (acc0 || !s0_valid) begin
                s0_valid = ($urandom_range(0, 2) != 0);
                s0_x = 8'($urandom); s0_y = 8'($urandom); s0_z = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                s0_valid = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                s0_x = 8'($urandom); s0_z = 8'($urandom);
            end
            if (acc1 || !s1_valid) begin
                s1_valid = ($urandom_range(0, 2) != 0);
                s1_x = 8'($urandom); s1_y = 8'($urandom); s1_z = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                s1_valid = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                s1_y = 8'($urandom); s1_z = 8'($urandom);
            end
        end
        s0_valid = 0; s1_valid = 0;
        chk("random_jobs_issued", issued >= 1000, 1);
        m_ready = 1;
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
